dcache_array: RTL

- Parametrised set-associative data-cache storage array for the LSQ/memory path; successor to the fixed 64-bit, single-store-size cache memory.
- Holds tag, valid, dirty, data and true-LRU age state per set. Provides a registered load lookup, byte-enable store merge and line fill from memory.
- On fill, replaces the LRU or first invalid way and emits a one-cycle writeback of a dirty victim. Sits between the LSQ and the memory controller.

---
 rtl/dcache_array.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dcache_array.sv
// Set-associative data-cache array: registered load lookup, byte-merge store, line fill with true-LRU victim choice.
// All results appear one cycle after the request; there is no backpressure, and every request is accepted.
module dcache_array #(
  parameter int SETS       = 16,
  parameter int WAYS       = 4,
  parameter int LINE_BYTES = 8,
  parameter int TAG_W      = 9,
  parameter int IDX_W      = $clog2(SETS),
  parameter int LW         = $clog2(WAYS)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    rd_en,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic [TAG_W-1:0]        rd_tag,
  output logic                    rd_valid,
  output logic                    rd_hit,
  output logic [8*LINE_BYTES-1:0] rd_data,
  input  logic                    st_en,
  input  logic [IDX_W-1:0]        st_idx,
  input  logic [TAG_W-1:0]        st_tag,
  input  logic [8*LINE_BYTES-1:0] st_data,
  input  logic [LINE_BYTES-1:0]   st_be,
  output logic                    st_done,
  output logic                    st_hit,
  input  logic                    fill_en,
  input  logic [IDX_W-1:0]        fill_idx,
  input  logic [TAG_W-1:0]        fill_tag,
  input  logic [8*LINE_BYTES-1:0] fill_data,
  output logic                    evict_valid,
  output logic [IDX_W-1:0]        evict_idx,
  output logic [TAG_W-1:0]        evict_tag,
  output logic [8*LINE_BYTES-1:0] evict_data
);

  localparam int DW = 8 * LINE_BYTES;

  typedef logic [WAYS-1:0][LW-1:0] age_t;

  logic [WAYS-1:0]  valid_q [SETS];
  logic [WAYS-1:0]  dirty_q [SETS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [DW-1:0]    data_q  [SETS][WAYS];
  age_t             age_q   [SETS];

  logic          rd_hit_c, st_hit_c, fill_match, fill_inv;
  logic [LW-1:0] rd_way, st_way, match_way, inv_way, lru_way, fill_way;
  logic          st_do, rd_touch, evict_c;

  // Ways younger than the touched one slide down by one; the touched way becomes MRU.
  function automatic age_t touch(input age_t a, input logic [LW-1:0] w);
    age_t r;
    r = a;
    for (int i = 0; i < WAYS; i++)
      if (a[i] > a[w]) r[i] = a[i] - LW'(1);
    r[w] = LW'(WAYS - 1);
    return r;
  endfunction

  always_comb begin
    rd_hit_c   = 1'b0;
    rd_way     = '0;
    st_hit_c   = 1'b0;
    st_way     = '0;
    fill_match = 1'b0;
    match_way  = '0;
    fill_inv   = 1'b0;
    inv_way    = '0;
    lru_way    = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[rd_idx][w] && tag_q[rd_idx][w] == rd_tag) begin
        rd_hit_c = 1'b1;
        rd_way   = LW'(w);
      end
      if (valid_q[st_idx][w] && tag_q[st_idx][w] == st_tag) begin
        st_hit_c = 1'b1;
        st_way   = LW'(w);
      end
      if (valid_q[fill_idx][w] && tag_q[fill_idx][w] == fill_tag) begin
        fill_match = 1'b1;
        match_way  = LW'(w);
      end
      if (age_q[fill_idx][w] == '0) lru_way = LW'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[fill_idx][w]) begin
        fill_inv = 1'b1;
        inv_way  = LW'(w);
      end
    end
    fill_way = fill_match ? match_way : (fill_inv ? inv_way : lru_way);
    evict_c  = fill_en && !fill_match && valid_q[fill_idx][fill_way] && dirty_q[fill_idx][fill_way];
    st_do    = st_en && st_hit_c && !(fill_en && fill_idx == st_idx);
    rd_touch = rd_en && rd_hit_c && !(fill_en && fill_idx == rd_idx) && !(st_do && st_idx == rd_idx);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          tag_q[s][w]  <= '0;
          data_q[s][w] <= '0;
          age_q[s][w]  <= LW'(w);
        end
      end
      rd_valid    <= 1'b0;
      rd_hit      <= 1'b0;
      rd_data     <= '0;
      st_done     <= 1'b0;
      st_hit      <= 1'b0;
      evict_valid <= 1'b0;
      evict_idx   <= '0;
      evict_tag   <= '0;
      evict_data  <= '0;
    end else begin
      rd_valid    <= rd_en;
      rd_hit      <= rd_en && rd_hit_c;
      rd_data     <= (rd_en && rd_hit_c) ? data_q[rd_idx][rd_way] : '0;
      st_done     <= st_en;
      st_hit      <= st_do;
      evict_valid <= evict_c;
      evict_idx   <= evict_c ? fill_idx : '0;
      evict_tag   <= evict_c ? tag_q[fill_idx][fill_way] : '0;
      evict_data  <= evict_c ? data_q[fill_idx][fill_way] : '0;

      if (st_do) begin
        for (int b = 0; b < LINE_BYTES; b++)
          if (st_be[b]) data_q[st_idx][st_way][8*b +: 8] <= st_data[8*b +: 8];
        if (|st_be) dirty_q[st_idx][st_way] <= 1'b1;
        age_q[st_idx] <= touch(age_q[st_idx], st_way);
      end
      if (fill_en) begin
        data_q[fill_idx][fill_way]  <= fill_data;
        tag_q[fill_idx][fill_way]   <= fill_tag;
        valid_q[fill_idx][fill_way] <= 1'b1;
        dirty_q[fill_idx][fill_way] <= 1'b0;
        age_q[fill_idx]             <= touch(age_q[fill_idx], fill_way);
      end
      if (rd_touch) age_q[rd_idx] <= touch(age_q[rd_idx], rd_way);
    end
  end

endmodule
